// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_pkg
//  Purpose  : Shared types, encodings and decode helpers for ctrl_fsm_gen
//  Revision : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    // Controller states
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_INIT   = 4'd1,
        ST_FETCH1 = 4'd2,
        ST_FETCH2 = 4'd3,
        ST_FETCH3 = 4'd4,
        ST_EXEC1  = 4'd5,
        ST_EXEC2  = 4'd6,
        ST_EXEC3  = 4'd7,
        ST_EXEC4  = 4'd8,
        ST_HALT   = 4'd9
    } state_t;

    // Opcodes (low nibble of the instruction register)
    localparam logic [3:0] c_OPC_LDAC   = 4'h0;
    localparam logic [3:0] c_OPC_MVACR  = 4'h1;
    localparam logic [3:0] c_OPC_ADDTR  = 4'h2;
    localparam logic [3:0] c_OPC_MVACTR = 4'h3;
    localparam logic [3:0] c_OPC_STTR   = 4'h4;
    localparam logic [3:0] c_OPC_MULT   = 4'h5;
    localparam logic [3:0] c_OPC_SUB    = 4'h6;
    localparam logic [3:0] c_OPC_CLR    = 4'h7;
    localparam logic [3:0] c_OPC_INCAC  = 4'h8;
    localparam logic [3:0] c_OPC_JUMP   = 4'h9;
    localparam logic [3:0] c_OPC_JPZ    = 4'hA;
    localparam logic [3:0] c_OPC_JPNZ   = 4'hB;
    localparam logic [3:0] c_OPC_ENDOP  = 4'hC;

    // Write-enable bit positions
    localparam int c_WE_ARB = 7;
    localparam int c_WE_AR  = 6;
    localparam int c_WE_PC  = 5;
    localparam int c_WE_DR  = 4;
    localparam int c_WE_IR  = 3;
    localparam int c_WE_R   = 2;
    localparam int c_WE_TR  = 1;
    localparam int c_WE_AC  = 0;

    // Bus source select codes
    localparam logic [2:0] c_BUS_IMEM = 3'd0;
    localparam logic [2:0] c_BUS_DMEM = 3'd1;
    localparam logic [2:0] c_BUS_PC   = 3'd2;
    localparam logic [2:0] c_BUS_DR   = 3'd3;
    localparam logic [2:0] c_BUS_R    = 3'd4;
    localparam logic [2:0] c_BUS_AC   = 3'd5;
    localparam logic [2:0] c_BUS_TR   = 3'd6;

    // ALU function codes
    localparam logic [3:0] c_ALU_ADD  = 4'd0;
    localparam logic [3:0] c_ALU_SUB  = 4'd1;
    localparam logic [3:0] c_ALU_MUL  = 4'd2;
    localparam logic [3:0] c_ALU_PASS = 4'd5;

    // Increment / clear strobe encodings
    localparam logic [1:0] c_INC_NONE = 2'b00;
    localparam logic [1:0] c_INC_PC   = 2'b01;
    localparam logic [1:0] c_INC_AC   = 2'b10;
    localparam logic [2:0] c_CLR_NONE = 3'b000;
    localparam logic [2:0] c_CLR_ALL  = 3'b111;
    localparam logic [2:0] c_CLR_ACTR = 3'b110;

    // Conditional branch resolves on the zero flag latched at the end of fetch
    function automatic logic br_taken(input logic [3:0] opc, input logic zq);
        return ((opc == c_OPC_JPZ) && zq) || ((opc == c_OPC_JPNZ) && !zq);
    endfunction

    // States that touch memory and therefore stretch by the wait-state count
    function automatic logic is_mem_state(input state_t st, input logic [3:0] opc,
                                          input logic zq);
        logic v;
        v = 1'b0;
        case (st)
            ST_FETCH2: v = 1'b1;
            ST_EXEC1:  v = (opc == c_OPC_LDAC) || (opc == c_OPC_STTR) ||
                           (opc == c_OPC_JUMP) || br_taken(opc, zq);
            ST_EXEC3:  v = (opc == c_OPC_LDAC) || (opc == c_OPC_STTR);
            default:   v = 1'b0;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_fsm_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_fsm_gen_if
//  Purpose  : Handshake and datapath-control bundle of the CPU controller
//  Revision : 1.0 - initial release
// ============================================================================
interface ctrl_fsm_gen_if #(
    parameter int IR_W  = 8,
    parameter int WE_W  = 8,
    parameter int ALU_W = 4
) ();
    logic              start;
    logic [IR_W-1:0]   ir;
    logic              z;
    logic              busy;
    logic              end_op;
    logic [1:0]        inc;
    logic [ALU_W-1:0]  alu_mode;
    logic [2:0]        bus_ld;
    logic [WE_W-1:0]   write_en;
    logic [2:0]        clr;
    logic              dm_wr;
    logic              im_wr;

    // Controller side
    modport master (
        input  start, ir, z,
        output busy, end_op, inc, alu_mode, bus_ld, write_en, clr, dm_wr, im_wr
    );

    // Datapath / host side
    modport slave (
        output start, ir, z,
        input  busy, end_op, inc, alu_mode, bus_ld, write_en, clr, dm_wr, im_wr
    );
endinterface
`default_nettype wire

// File: rtl/ctrl_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_wait_timer
//  Purpose  : Loadable down-counter flagging first/last cycle of a memory state
//  Revision : 1.0 - initial release
// ============================================================================
module ctrl_wait_timer #(
    parameter int               CNT_W    = 4,
    parameter logic [CNT_W-1:0] LOAD_VAL = '0
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_load,
    input  wire logic i_dec,
    output logic      o_first,
    output logic      o_last
);
    logic [CNT_W-1:0] r_cnt;

    // Reload on every state change, count down while a memory state is stretched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_first = (r_cnt == LOAD_VAL);
    assign o_last  = (r_cnt == '0);
endmodule
`default_nettype wire

// File: rtl/ctrl_fsm_gen.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_fsm_gen
//  Purpose  : Fetch/execute control FSM with start/halt handshake and
//             configurable memory wait states
//  Revision : 1.0 - initial release
// ============================================================================
module ctrl_fsm_gen
    import ctrl_pkg::*;
#(
    parameter int IR_W    = 8,
    parameter int OPC_W   = 4,
    parameter int WE_W    = 8,
    parameter int ALU_W   = 4,
    parameter int MEM_LAT = 0
) (
    input  wire logic        clk,
    input  wire logic        rst,
    ctrl_fsm_gen_if.master   ctl
);
    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_zq;
    logic [3:0]      w_opc;
    logic            w_mem;
    logic            w_first;
    logic            w_last;
    logic            w_load;
    logic [WE_W-1:0] w_we;
    logic [1:0]      w_inc;
    logic [2:0]      w_clr;
    logic [2:0]      w_bus;
    logic [3:0]      w_alu;
    logic            w_dm;
    logic            w_eop;

    // Only the opcode field of the instruction register is decoded
    assign w_opc = 4'(ctl.ir[OPC_W-1:0]);

    generate
        if (IR_W > OPC_W) begin : g_ir_unused
            logic w_unused_ir;
            assign w_unused_ir = ^ctl.ir[IR_W-1:OPC_W];
        end
    endgenerate

    assign w_mem  = is_mem_state(r_state, w_opc, r_zq);
    assign w_load = (w_state_nxt != r_state);

    ctrl_wait_timer #(
        .CNT_W    (4),
        .LOAD_VAL (4'(MEM_LAT))
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_dec   (w_mem & ~w_last),
        .o_first (w_first),
        .o_last  (w_last)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Zero flag is frozen as the instruction leaves fetch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_zq <= 1'b0;
        end else if (r_state == ST_FETCH3) begin
            r_zq <= ctl.z;
        end
    end

    // Next-state and micro-operation decode
    always_comb begin
        w_state_nxt = r_state;
        w_we        = '0;
        w_inc       = c_INC_NONE;
        w_clr       = c_CLR_NONE;
        w_bus       = c_BUS_IMEM;
        w_alu       = c_ALU_ADD;
        w_dm        = 1'b0;
        w_eop       = 1'b0;
        case (r_state)
            ST_IDLE, ST_HALT: begin
                if (ctl.start) w_state_nxt = ST_INIT;
            end
            ST_INIT: begin
                w_clr       = c_CLR_ALL;
                w_state_nxt = ST_FETCH1;
            end
            ST_FETCH1: begin
                w_we[c_WE_AR] = 1'b1;
                w_bus         = c_BUS_PC;
                w_state_nxt   = ST_FETCH2;
            end
            ST_FETCH2: begin
                w_bus = c_BUS_IMEM;
                if (w_last) begin
                    w_we[c_WE_DR] = 1'b1;
                    w_inc         = c_INC_PC;
                    w_state_nxt   = ST_FETCH3;
                end
            end
            ST_FETCH3: begin
                w_we[c_WE_IR] = 1'b1;
                w_bus         = c_BUS_DR;
                w_state_nxt   = ST_EXEC1;
            end
            ST_EXEC1: begin
                w_state_nxt = ST_FETCH1;
                case (w_opc)
                    c_OPC_LDAC, c_OPC_STTR, c_OPC_JUMP, c_OPC_JPZ, c_OPC_JPNZ: begin
                        if (w_mem) begin
                            // Operand fetch; a not-taken branch only skips it
                            w_bus = c_BUS_IMEM;
                            if (w_last) begin
                                w_we[c_WE_DR] = 1'b1;
                                w_state_nxt   = ST_EXEC2;
                            end else begin
                                w_state_nxt   = ST_EXEC1;
                            end
                        end else begin
                            w_inc = c_INC_PC;
                        end
                    end
                    c_OPC_MVACR: begin
                        w_we[c_WE_R] = 1'b1;
                        w_bus        = c_BUS_AC;
                    end
                    c_OPC_ADDTR: begin
                        w_we[c_WE_AC] = 1'b1;
                        w_bus         = c_BUS_TR;
                        w_alu         = c_ALU_ADD;
                    end
                    c_OPC_MVACTR: begin
                        w_we[c_WE_TR] = 1'b1;
                        w_bus         = c_BUS_AC;
                    end
                    c_OPC_MULT: begin
                        w_we[c_WE_AC] = 1'b1;
                        w_bus         = c_BUS_R;
                        w_alu         = c_ALU_MUL;
                    end
                    c_OPC_SUB: begin
                        w_we[c_WE_AC] = 1'b1;
                        w_bus         = c_BUS_R;
                        w_alu         = c_ALU_SUB;
                    end
                    c_OPC_CLR:   w_clr = c_CLR_ACTR;
                    c_OPC_INCAC: w_inc = c_INC_AC;
                    c_OPC_ENDOP: begin
                        w_eop       = 1'b1;
                        w_state_nxt = ST_HALT;
                    end
                    default: ;
                endcase
            end
            ST_EXEC2: begin
                w_state_nxt = ST_FETCH1;
                case (w_opc)
                    c_OPC_LDAC, c_OPC_STTR: begin
                        w_we[c_WE_AR] = 1'b1;
                        w_bus         = c_BUS_DR;
                        w_inc         = c_INC_PC;
                        w_state_nxt   = ST_EXEC3;
                    end
                    c_OPC_JUMP, c_OPC_JPZ, c_OPC_JPNZ: begin
                        w_we[c_WE_PC] = 1'b1;
                        w_bus         = c_BUS_DR;
                    end
                    default: ;
                endcase
            end
            ST_EXEC3: begin
                w_state_nxt = ST_FETCH1;
                case (w_opc)
                    c_OPC_LDAC: begin
                        w_bus = c_BUS_DMEM;
                        if (w_last) begin
                            w_we[c_WE_DR] = 1'b1;
                            w_state_nxt   = ST_EXEC4;
                        end else begin
                            w_state_nxt   = ST_EXEC3;
                        end
                    end
                    c_OPC_STTR: begin
                        // Single write strobe, bus held while memory completes
                        w_bus = c_BUS_TR;
                        w_dm  = w_first;
                        if (!w_last) w_state_nxt = ST_EXEC3;
                    end
                    default: ;
                endcase
            end
            ST_EXEC4: begin
                w_state_nxt = ST_FETCH1;
                if (w_opc == c_OPC_LDAC) begin
                    w_we[c_WE_AC] = 1'b1;
                    w_bus         = c_BUS_DR;
                    w_alu         = c_ALU_PASS;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign ctl.busy     = (r_state != ST_IDLE) && (r_state != ST_HALT);
    assign ctl.end_op   = w_eop;
    assign ctl.inc      = w_inc;
    assign ctl.alu_mode = ALU_W'(w_alu);
    assign ctl.bus_ld   = w_bus;
    assign ctl.write_en = w_we;
    assign ctl.clr      = w_clr;
    assign ctl.dm_wr    = w_dm;
    assign ctl.im_wr    = 1'b0;
endmodule
`default_nettype wire

// File: tb/tb_ctrl_fsm_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ctrl_fsm_gen
//  Purpose  : Directed self-checking bench for ctrl_fsm_gen
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_fsm_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       r_start = 1'b0;
    logic [7:0] r_ir = 8'h00;
    logic       r_z = 1'b0;
    int         sel = 0;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    // Three controllers in lockstep, differing only in wait states
    ctrl_fsm_gen_if if0 ();
    ctrl_fsm_gen_if if2 ();
    ctrl_fsm_gen_if if3 ();

    assign if0.start = r_start;  assign if0.ir = r_ir;  assign if0.z = r_z;
    assign if2.start = r_start;  assign if2.ir = r_ir;  assign if2.z = r_z;
    assign if3.start = r_start;  assign if3.ir = r_ir;  assign if3.z = r_z;

    ctrl_fsm_gen #(.MEM_LAT(0)) u_dut0 (.clk(clk), .rst(rst), .ctl(if0));
    ctrl_fsm_gen #(.MEM_LAT(2)) u_dut2 (.clk(clk), .rst(rst), .ctl(if2));
    ctrl_fsm_gen #(.MEM_LAT(3)) u_dut3 (.clk(clk), .rst(rst), .ctl(if3));

    // {busy, end_op, inc, alu_mode, bus_ld, write_en, clr, dm_wr, im_wr}
    logic [23:0] o0, o2, o3;
    assign o0 = {if0.busy, if0.end_op, if0.inc, if0.alu_mode, if0.bus_ld,
                 if0.write_en, if0.clr, if0.dm_wr, if0.im_wr};
    assign o2 = {if2.busy, if2.end_op, if2.inc, if2.alu_mode, if2.bus_ld,
                 if2.write_en, if2.clr, if2.dm_wr, if2.im_wr};
    assign o3 = {if3.busy, if3.end_op, if3.inc, if3.alu_mode, if3.bus_ld,
                 if3.write_en, if3.clr, if3.dm_wr, if3.im_wr};

    function automatic logic [23:0] obs();
        case (sel)
            2:       return o2;
            3:       return o3;
            default: return o0;
        endcase
    endfunction

    function automatic logic [23:0] ev(input logic b, input logic eo,
                                       input logic [1:0] inc, input logic [3:0] alu,
                                       input logic [2:0] bus, input logic [7:0] we,
                                       input logic [2:0] clr, input logic dm);
        return {b, eo, inc, alu, bus, we, clr, dm, 1'b0};
    endfunction

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the current cycle, then advance one clock
    task automatic cyc(input string tag, input logic [23:0] e);
        check(tag, obs(), e);
        step();
    endtask

    // Memory state of ml+1 cycles: bus held, dm on first, we/inc on last
    task automatic mem(input string tag, input int ml, input logic [2:0] bus,
                       input logic [7:0] we, input logic [1:0] inc, input logic dm);
        for (int i = 0; i <= ml; i++)
            cyc(tag, ev(1'b1, 1'b0, (i == ml) ? inc : 2'b00, 4'd0, bus,
                        (i == ml) ? we : 8'h00, 3'd0, (i == 0) ? dm : 1'b0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        r_start = 1'b0;
        step();
        check("reset", obs(), 24'h0);
        rst = 1'b0;
    endtask

    task automatic launch();
        r_start = 1'b1;
        step();
        r_start = 1'b0;
        cyc("init", ev(1, 0, 2'b00, 4'd0, 3'd0, 8'h00, 3'b111, 0));
    endtask

    task automatic fetch(input int ml);
        cyc("fetch1", ev(1, 0, 2'b00, 4'd0, 3'd2, 8'h40, 3'd0, 0));
        mem("fetch2", ml, 3'd0, 8'h10, 2'b01, 1'b0);
        cyc("fetch3", ev(1, 0, 2'b00, 4'd0, 3'd3, 8'h08, 3'd0, 0));
    endtask

    localparam logic [23:0] c_F1 = {1'b1, 1'b0, 2'b00, 4'd0, 3'd2, 8'h40, 3'd0, 1'b0, 1'b0};

    initial begin
        // 1: ENDOP, no wait states
        sel = 0; r_ir = 8'h0C;
        do_reset();
        launch();
        fetch(0);
        cyc("endop", ev(1, 1, 2'b00, 4'd0, 3'd0, 8'h00, 3'd0, 0));
        cyc("halt", 24'h0);
        cyc("halt_hold", 24'h0);

        // 2a: LDAC, MEM_LAT=0 -> 7 cycles FETCH1 to FETCH1
        sel = 0; r_ir = 8'h00;
        do_reset();
        launch();
        fetch(0);
        mem("ld_e1", 0, 3'd0, 8'h10, 2'b00, 1'b0);
        cyc("ld_e2", ev(1, 0, 2'b01, 4'd0, 3'd3, 8'h40, 3'd0, 0));
        mem("ld_e3", 0, 3'd1, 8'h10, 2'b00, 1'b0);
        cyc("ld_e4", ev(1, 0, 2'b00, 4'd5, 3'd3, 8'h01, 3'd0, 0));
        cyc("ld_next", c_F1);

        // 2b: LDAC, MEM_LAT=2 -> 13 cycles
        sel = 2; r_ir = 8'h00;
        do_reset();
        launch();
        fetch(2);
        mem("ld2_e1", 2, 3'd0, 8'h10, 2'b00, 1'b0);
        cyc("ld2_e2", ev(1, 0, 2'b01, 4'd0, 3'd3, 8'h40, 3'd0, 0));
        mem("ld2_e3", 2, 3'd1, 8'h10, 2'b00, 1'b0);
        cyc("ld2_e4", ev(1, 0, 2'b00, 4'd5, 3'd3, 8'h01, 3'd0, 0));
        cyc("ld2_next", c_F1);

        // 3: STTR, MEM_LAT=3
        sel = 3; r_ir = 8'h04;
        do_reset();
        launch();
        fetch(3);
        mem("st_e1", 3, 3'd0, 8'h10, 2'b00, 1'b0);
        cyc("st_e2", ev(1, 0, 2'b01, 4'd0, 3'd3, 8'h40, 3'd0, 0));
        mem("st_e3", 3, 3'd6, 8'h00, 2'b00, 1'b1);
        cyc("st_next", c_F1);

        // 4a: JPZ taken; z drops after being latched
        sel = 0; r_ir = 8'h0A; r_z = 1'b1;
        do_reset();
        launch();
        fetch(0);
        r_z = 1'b0;
        cyc("jpz_e1", ev(1, 0, 2'b00, 4'd0, 3'd0, 8'h10, 3'd0, 0));
        cyc("jpz_e2", ev(1, 0, 2'b00, 4'd0, 3'd3, 8'h20, 3'd0, 0));
        cyc("jpz_next", c_F1);

        // 4b: JPZ not taken
        r_z = 1'b0;
        do_reset();
        launch();
        fetch(0);
        cyc("jpz_nt", ev(1, 0, 2'b01, 4'd0, 3'd0, 8'h00, 3'd0, 0));
        cyc("jpz_nt_next", c_F1);

        // 5: junk upper nibble -> MULT; 0x0E -> NOP
        r_ir = 8'hF5;
        do_reset();
        launch();
        fetch(0);
        cyc("mult", ev(1, 0, 2'b00, 4'd2, 3'd4, 8'h01, 3'd0, 0));
        cyc("mult_next", c_F1);
        r_ir = 8'h0E;
        do_reset();
        launch();
        fetch(0);
        cyc("nop", ev(1, 0, 2'b00, 4'd0, 3'd0, 8'h00, 3'd0, 0));
        cyc("nop_next", c_F1);

        // 6a: start held high during execution does not restart
        do_reset();
        r_start = 1'b1;
        step();
        cyc("init_hold", ev(1, 0, 2'b00, 4'd0, 3'd0, 8'h00, 3'b111, 0));
        fetch(0);
        cyc("nop_hold", ev(1, 0, 2'b00, 4'd0, 3'd0, 8'h00, 3'd0, 0));
        cyc("no_restart", c_F1);

        // 6b: asynchronous reset in EXEC3 of STTR
        sel = 3; r_ir = 8'h04;
        do_reset();
        r_start = 1'b1;
        step();
        cyc("init_st", ev(1, 0, 2'b00, 4'd0, 3'd0, 8'h00, 3'b111, 0));
        fetch(3);
        mem("st_e1b", 3, 3'd0, 8'h10, 2'b00, 1'b0);
        cyc("st_e2b", ev(1, 0, 2'b01, 4'd0, 3'd3, 8'h40, 3'd0, 0));
        check("st_e3_dm", obs(), ev(1, 0, 2'b00, 4'd0, 3'd6, 8'h00, 3'd0, 1));
        #1 rst = 1'b1;
        #1 check("async_rst", obs(), 24'h0);
        step();
        rst = 1'b0;
        r_start = 1'b0;
        step();
        check("idle_after_rst", obs(), 24'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ctrl_fsm_gen.md
Name: ctrl_fsm_gen

Overview:
- Parametrised successor of the processor control FSM for the single-core matrix-multiplier CPU.
- Sequences fetch/execute micro-operations for the 4-bit opcode ISA.
- Adds reset, start/busy/halt handshake, latched zero flag and configurable memory wait states.
- Drives datapath register write enables, bus source select, ALU mode, increment/clear strobes and memory writes.

Parameters:
- IR_W, 8: instruction register width; opcode is ir[OPC_W-1:0], upper bits ignored.
- OPC_W, 4: opcode field width.
- WE_W, 8: write-enable vector width (bit7 ARB, 6 AR, 5 PC, 4 DR, 3 IR, 2 R, 1 TR, 0 AC).
- ALU_W, 4: ALU mode width (0 add, 1 sub, 2 mul, 5 pass).
- MEM_LAT, 0: extra wait cycles per memory-access state (0..15).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  level; launches execution from IDLE or HALT.
- ir  in  IR_W  instruction register contents.
- z  in  1  ALU zero flag.
- busy  out  1  high from launch until HALT.
- end_op  out  1  one-cycle pulse on ENDOP execution.
- inc  out  2  01 inc PC, 10 inc AC.
- alu_mode  out  ALU_W  ALU function.
- bus_ld  out  3  bus source (0 IMEM, 1 DMEM, 2 PC, 3 DR, 4 R, 5 AC, 6 TR).
- write_en  out  WE_W  register load strobes.
- clr  out  3  clear strobes (bit2 AC, bit1 TR, bit0 PC).
- dm_wr  out  1  data-memory write.
- im_wr  out  1  instruction-memory write; tied 0 in this generation.

Behaviour:
- **Outputs.** All outputs are combinational decodes of the registered state, wait counter, latched zero flag (zq) and ir. Default when undriven: write_en=0, inc=0, clr=0, dm_wr=0, end_op=0, bus_ld=0, alu_mode=0.
- **Reset.** On rst: state=IDLE, wcnt=0, zq=0, so every output is 0.
- **States.** IDLE, INIT, FETCH1, FETCH2, FETCH3, EXEC1..EXEC4, HALT.
- **IDLE/HALT.** Hold until start=1, then go to INIT. busy=0 in IDLE/HALT; busy=1 in all other states.
- **INIT.** clr=111 for one cycle, then FETCH1.
- **Fetch sequence.**
  - FETCH1: AR<-PC (we bit6, bus 2).
  - FETCH2 (mem): DR<-IMEM (bus 0).
  - FETCH3: IR<-DR (bus 3); zq<=z on exit; next EXEC1.
- **Memory wait states.** A memory-access state lasts MEM_LAT+1 cycles, counted by wcnt.
  - bus_ld is held for the whole state.
  - write_en and inc are asserted only on the final cycle.
  - dm_wr is asserted only on the first cycle.
- **Per-opcode sequences** (unlisted states go to FETCH1):
  - 0 LDAC: E1 mem DR<-IMEM; E2 AR<-DR, inc PC; E3 mem DR<-DMEM; E4 AC<-DR, alu pass.
  - 1 MVACR: E1 R<-AC.
  - 2 ADDTR: E1 AC<-TR, alu add.
  - 3 MVACTR: E1 TR<-AC.
  - 4 STTR: E1 mem DR<-IMEM; E2 AR<-DR, inc PC; E3 mem bus TR, dm_wr.
  - 5 MULT: E1 AC<-R, alu mul.
  - 6 SUB: E1 AC<-R, alu sub.
  - 7 CLR: E1 clr=110.
  - 8 INCAC: E1 inc=10.
  - 9 JUMP: E1 mem DR<-IMEM; E2 PC<-DR (bus 3).
  - A JPZ: taken if zq=1, executes as JUMP; not taken: E1 inc PC only (skips operand), then FETCH1.
  - B JPNZ: as JPZ with zq=0 as the taken condition.
  - C ENDOP: E1 end_op=1, then HALT.
  - D-F NOP: E1 drives nothing, then FETCH1.
- **Zero flag.** z changes after FETCH3 do not affect branch decisions.
- **start during execution.** Ignored while busy.
- **Reset mid-instruction.** Immediate return to IDLE; no partial dm_wr beyond the current cycle.

Decomposition:
- Package ctrl_pkg holds:
  - state enum;
  - opcode constants;
  - write-enable bit indices;
  - bus source codes;
  - ALU mode codes;
  - inc/clr encodings.
- One sub-module, ctrl_wait_timer: loadable down-counter generating first/last-cycle flags for memory states.

Test Plan:
1. rst pulse, then start=1 with ir=0x0C (ENDOP), MEM_LAT=0: INIT clr=111 → FETCH1-3 → end_op pulses 1 cycle in EXEC1 → HALT, busy=0 from the next cycle.
2. LDAC (ir=0x00), MEM_LAT=0: exactly 7 cycles FETCH1→FETCH1. Check DR/AR/DR/AC loads in order, inc=01 in FETCH2 and EXEC2, alu_mode=5 in EXEC4. Same with MEM_LAT=2: 13 cycles, DR write only on the last cycle of each memory state.
3. STTR (ir=0x04), MEM_LAT=3: dm_wr high exactly 1 cycle at EXEC3 entry; bus_ld=6 held for 4 cycles.
4. JPZ (ir=0x0A), z=1 at FETCH3, toggled to 0 during EXEC1: branch taken, write_en=0x20 with bus 3 in EXEC2. Repeat with z=0: inc=01 in EXEC1 only, then FETCH1.
5. ir=0xF5 (upper nibble junk) executes MULT: write_en=0x01, alu_mode=2, bus_ld=4. ir=0x0E executes as NOP with all outputs 0.
6. rst asserted during EXEC3 of STTR: all outputs 0 immediately (asynchronous). start held high during execution causes no restart.
